ucie_ctl_sb_tx_scheduler: RTL and testbench



---
 rtl/ucie_ctl_sb_pkg.sv | 36 +++
 rtl/ucie_ctl_sb_tx_scheduler_if.sv | 32 +++
 rtl/UCIE_ctl_parity_generator.sv | 22 ++
 rtl/ucie_ctl_sb_tx_scheduler.sv | 138 +++++++++++++
 tb/tb_ucie_ctl_sb_tx_scheduler.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ucie_ctl_sb_pkg.sv
// Shared types and constants for the UCIe sideband transmit scheduler.
package ucie_ctl_sb_pkg;

   localparam int PHASE0_W           = 32;
   localparam int PHASE1_W           = 30;
   localparam int DATA_W             = 64;
   localparam int WORD_W             = 32;
   localparam int GAP_CNT_W          = 4;
   localparam int GAP_CYCLES_DEFAULT = 2;

   // Position of each word inside a packet on the serial stream.
   localparam int WORD_HDR0 = 0;
   localparam int WORD_HDR1 = 1;
   localparam int WORD_DAT0 = 2;
   localparam int WORD_DAT1 = 3;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CALC,
      ST_HDR0,
      ST_HDR1,
      ST_DAT0,
      ST_DAT1,
      ST_GAP
   } state_e;

   // Two-way round-robin pick: a lone request wins outright, a tie goes to rr.
   function automatic logic rr_pick(input logic [1:0] valid, input logic rr);
      logic winner;
      winner = rr;
      if (valid == 2'b01) winner = 1'b0;
      else if (valid == 2'b10) winner = 1'b1;
      return winner;
   endfunction

endpackage

// File: rtl/ucie_ctl_sb_tx_scheduler_if.sv
// Request and transmit-stream bundle between requesters/serializer and the scheduler.
interface ucie_ctl_sb_tx_scheduler_if;
   import ucie_ctl_sb_pkg::*;

   logic [1:0]          i_req_valid;
   logic [PHASE0_W-1:0] i_req0_phase0;
   logic [PHASE0_W-1:0] i_req1_phase0;
   logic [PHASE1_W-1:0] i_req0_phase1;
   logic [PHASE1_W-1:0] i_req1_phase1;
   logic                i_req0_has_data;
   logic                i_req1_has_data;
   logic [DATA_W-1:0]   i_req0_data;
   logic [DATA_W-1:0]   i_req1_data;
   logic [1:0]          o_req_ack;
   logic                o_tx_valid;
   logic [WORD_W-1:0]   o_tx_data;
   logic                o_tx_last;
   logic                i_tx_ready;

   modport master (
      output i_req_valid, i_req0_phase0, i_req1_phase0, i_req0_phase1, i_req1_phase1,
             i_req0_has_data, i_req1_has_data, i_req0_data, i_req1_data, i_tx_ready,
      input  o_req_ack, o_tx_valid, o_tx_data, o_tx_last
   );

   modport slave (
      input  i_req_valid, i_req0_phase0, i_req1_phase0, i_req0_phase1, i_req1_phase1,
             i_req0_has_data, i_req1_has_data, i_req0_data, i_req1_data, i_tx_ready,
      output o_req_ack, o_tx_valid, o_tx_data, o_tx_last
   );

endinterface

// File: rtl/UCIE_ctl_parity_generator.sv
// Sideband parity: cp covers the 62 header bits, dp covers the 64 payload bits.
module UCIE_ctl_parity_generator
   import ucie_ctl_sb_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [PHASE0_W-1:0] i_phase0,
   input  logic [PHASE1_W-1:0] i_phase1,
   input  logic [WORD_W-1:0]   i_data_hi,
   input  logic [WORD_W-1:0]   i_data_lo,
   output logic                o_cp,
   output logic                o_dp
);

   // Purely combinational; clock and reset are carried only for port compatibility.
   logic w_unused;
   assign w_unused = i_clk ^ i_rst;

   assign o_cp = ^{i_phase0, i_phase1};
   assign o_dp = ^{i_data_hi, i_data_lo};

endmodule

// File: rtl/ucie_ctl_sb_tx_scheduler.sv
// Sideband TX scheduler: round-robin grant of two requesters, parity, 32-bit word
// serialization over valid/ready, and a fixed idle gap after every packet.
module ucie_ctl_sb_tx_scheduler
   import ucie_ctl_sb_pkg::*;
#(
   parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   ucie_ctl_sb_tx_scheduler_if.slave   sb,
   output logic                        o_busy
);

   localparam logic [GAP_CNT_W-1:0] GAP_LOAD  = GAP_CNT_W'(GAP_CYCLES - 1);
   localparam state_e               AFTER_PKT = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;

   state_e              r_state;
   state_e              w_next_state;
   logic                r_rr;
   logic                r_winner;
   logic [PHASE0_W-1:0] r_phase0;
   logic [PHASE1_W-1:0] r_phase1;
   logic                r_has_data;
   logic [DATA_W-1:0]   r_data;
   logic                r_cp;
   logic                r_dp;
   logic [GAP_CNT_W-1:0] r_gap_cnt;

   logic                w_grant;
   logic                w_winner;
   logic                w_sel_has_data;
   logic [DATA_W-1:0]   w_sel_data;
   logic                w_cp;
   logic                w_dp;
   logic [1:0]          w_ack;
   logic                w_tx_valid;
   logic [WORD_W-1:0]   w_tx_data;
   logic                w_tx_last;

   // The last GAP cycle doubles as an arbitration slot so back-to-back traffic
   // sees exactly GAP_CYCLES dead cycles.
   assign w_grant = ((r_state == ST_IDLE) || (r_state == ST_GAP && r_gap_cnt == '0))
                    && (|sb.i_req_valid);
   assign w_winner       = rr_pick(sb.i_req_valid, r_rr);
   assign w_sel_has_data = w_winner ? sb.i_req1_has_data : sb.i_req0_has_data;
   assign w_sel_data     = w_winner ? sb.i_req1_data : sb.i_req0_data;

   UCIE_ctl_parity_generator u_parity (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_phase0  (r_phase0),
      .i_phase1  (r_phase1),
      .i_data_hi (r_data[DATA_W-1:WORD_W]),
      .i_data_lo (r_data[WORD_W-1:0]),
      .o_cp      (w_cp),
      .o_dp      (w_dp)
   );

   // NOTE: every output gets a default before the case, so no path can infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_ack        = 2'b00;
      w_tx_valid   = 1'b0;
      w_tx_data    = '0;
      w_tx_last    = 1'b0;
      unique case (r_state)
         ST_IDLE: if (w_grant) w_next_state = ST_CALC;
         ST_CALC: begin
            w_ack        = r_winner ? 2'b10 : 2'b01;
            w_next_state = ST_HDR0;
         end
         ST_HDR0: begin
            w_tx_valid = 1'b1;
            w_tx_data  = r_phase0;
            if (sb.i_tx_ready) w_next_state = ST_HDR1;
         end
         ST_HDR1: begin
            w_tx_valid = 1'b1;
            w_tx_data  = {r_dp, r_cp, r_phase1};
            w_tx_last  = ~r_has_data;
            if (sb.i_tx_ready) w_next_state = r_has_data ? ST_DAT0 : AFTER_PKT;
         end
         ST_DAT0: begin
            w_tx_valid = 1'b1;
            w_tx_data  = r_data[DATA_W-1:WORD_W];
            if (sb.i_tx_ready) w_next_state = ST_DAT1;
         end
         ST_DAT1: begin
            w_tx_valid = 1'b1;
            w_tx_data  = r_data[WORD_W-1:0];
            w_tx_last  = 1'b1;
            if (sb.i_tx_ready) w_next_state = AFTER_PKT;
         end
         ST_GAP: if (r_gap_cnt == '0) w_next_state = w_grant ? ST_CALC : ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= ST_IDLE;
         r_rr       <= 1'b0;
         r_winner   <= 1'b0;
         r_phase0   <= '0;
         r_phase1   <= '0;
         r_has_data <= 1'b0;
         r_data     <= '0;
         r_cp       <= 1'b0;
         r_dp       <= 1'b0;
         r_gap_cnt  <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_grant) begin
            r_winner   <= w_winner;
            r_rr       <= ~w_winner;
            r_phase0   <= w_winner ? sb.i_req1_phase0 : sb.i_req0_phase0;
            r_phase1   <= w_winner ? sb.i_req1_phase1 : sb.i_req0_phase1;
            r_has_data <= w_sel_has_data;
            r_data     <= w_sel_has_data ? w_sel_data : '0;
         end
         // Parity is frozen for the whole packet once the capture has settled.
         if (r_state == ST_CALC) begin
            r_cp <= w_cp;
            r_dp <= w_dp;
         end
         if (w_next_state == ST_GAP && r_state != ST_GAP) r_gap_cnt <= GAP_LOAD;
         else if (r_state == ST_GAP && r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - GAP_CNT_W'(1);
      end
   end

   assign sb.o_req_ack  = w_ack;
   assign sb.o_tx_valid = w_tx_valid;
   assign sb.o_tx_data  = w_tx_data;
   assign sb.o_tx_last  = w_tx_last;
   assign o_busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ucie_ctl_sb_tx_scheduler.sv
// Self-checking bench: directed scenarios plus randomized traffic against a packet-level model.
module tb_ucie_ctl_sb_tx_scheduler;
   import ucie_ctl_sb_pkg::*;

   localparam int GAP = GAP_CYCLES_DEFAULT;

   typedef struct {
      logic [31:0] p0;
      logic [29:0] p1;
      logic        hd;
      logic [63:0] d;
   } pkt_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;

   ucie_ctl_sb_tx_scheduler_if sb ();

   ucie_ctl_sb_tx_scheduler #(.GAP_CYCLES(GAP)) dut (
      .i_clk  (clk),
      .i_rst  (rst),
      .sb     (sb),
      .o_busy (busy)
   );

   always #5 clk = ~clk;

   pkt_t        pend0[$];
   pkt_t        pend1[$];
   pkt_t        cur[2];
   logic [1:0]  req_v;
   logic        rdy;
   logic        model_rr;
   logic [32:0] exp_q[$];
   logic [32:0] got_q[$];
   int          ack_cyc[$];
   int          ack_who[$];
   int          last_cyc[$];
   int          req_cyc[$];
   int          ready_pct;
   int          req_pct;
   bit          bp_mode;
   int          stall_cnt;
   int          word_idx;
   logic        prev_stall;
   logic [32:0] prev_word;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic pkt_t rand_pkt();
      pkt_t p;
      p.p0 = $urandom;
      p.p1 = 30'($urandom);
      p.hd = 1'($urandom_range(1));
      p.d  = {$urandom, $urandom};
      return p;
   endfunction

   // Expected word stream of one packet, built from the packet format rules.
   function automatic void model_push(input pkt_t p);
      logic [63:0] d;
      logic        cp;
      logic        dp;
      d  = p.hd ? p.d : 64'd0;
      cp = ^{p.p0, p.p1};
      dp = ^d;
      exp_q.push_back({1'b0, p.p0});
      exp_q.push_back({~p.hd, dp, cp, p.p1});
      if (p.hd) begin
         exp_q.push_back({1'b0, d[63:32]});
         exp_q.push_back({1'b1, d[31:0]});
      end
   endfunction

   function automatic int predict_winner(input logic [1:0] v, input logic rr);
      if (v == 2'b11) return rr ? 1 : 0;
      return v[1] ? 1 : 0;
   endfunction

   function automatic void model_reset();
      exp_q.delete();
      model_rr   = 1'b0;
      prev_stall = 1'b0;
      word_idx   = 0;
      stall_cnt  = 0;
   endfunction

   function automatic void clear_logs();
      got_q.delete();
      ack_cyc.delete();
      ack_who.delete();
      last_cyc.delete();
      req_cyc.delete();
   endfunction

   task automatic drive();
      sb.i_req_valid     = req_v;
      sb.i_req0_phase0   = cur[0].p0;
      sb.i_req0_phase1   = cur[0].p1;
      sb.i_req0_has_data = cur[0].hd;
      sb.i_req0_data     = cur[0].d;
      sb.i_req1_phase0   = cur[1].p0;
      sb.i_req1_phase1   = cur[1].p1;
      sb.i_req1_has_data = cur[1].hd;
      sb.i_req1_data     = cur[1].d;
      sb.i_tx_ready      = rdy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic step();
      int          w;
      logic [32:0] word;
      tick();
      word = {sb.o_tx_last, sb.o_tx_data};
      if (prev_stall) check("hold_word", {sb.o_tx_valid, word}, {1'b1, prev_word});
      if (sb.o_req_ack != 2'b00) begin
         if (req_v == 2'b00) begin
            check("spurious_ack", sb.o_req_ack, 2'b00);
         end else begin
            w = predict_winner(req_v, model_rr);
            check("ack_winner", sb.o_req_ack, (w == 1) ? 2'b10 : 2'b01);
            model_push(cur[w]);
            model_rr = (w == 0);
            req_v[w] = 1'b0;
            ack_cyc.push_back(cyc);
            ack_who.push_back(w);
         end
      end
      if (!req_v[0] && pend0.size() > 0 && $urandom_range(99) < req_pct) begin
         cur[0]   = pend0.pop_front();
         req_v[0] = 1'b1;
         req_cyc.push_back(cyc);
      end
      if (!req_v[1] && pend1.size() > 0 && $urandom_range(99) < req_pct) begin
         cur[1]   = pend1.pop_front();
         req_v[1] = 1'b1;
         req_cyc.push_back(cyc);
      end
      if (bp_mode) rdy = !(sb.o_tx_valid && (word_idx == WORD_HDR1 || word_idx == WORD_DAT0)
                           && stall_cnt < 3);
      else rdy = ($urandom_range(99) < ready_pct);
      if (bp_mode && !rdy) stall_cnt++;
      drive();
      if (sb.o_tx_valid && rdy) begin
         got_q.push_back(word);
         if (exp_q.size() == 0) check("extra_word", exp_q.size(), 1);
         else check("word", word, exp_q.pop_front());
         if (sb.o_tx_last) begin
            last_cyc.push_back(cyc);
            word_idx = 0;
         end else begin
            word_idx++;
         end
         stall_cnt = 0;
      end
      prev_stall = sb.o_tx_valid && !rdy;
      prev_word  = word;
   endtask

   task automatic run_until_idle(input int max_cyc);
      int  k;
      bit  done;
      k    = 0;
      done = 1'b0;
      while (k < max_cyc && !done) begin
         step();
         k++;
         done = (pend0.size() == 0) && (pend1.size() == 0) && (req_v == 2'b00)
                && (exp_q.size() == 0) && !busy;
      end
      check("drain_done", done, 1'b1);
   endtask

   task automatic reset_dut();
      rst   = 1'b1;
      req_v = 2'b00;
      rdy   = 1'b0;
      drive();
      repeat (2) tick();
      rst = 1'b0;
      model_reset();
   endtask

   // Starts a req0 data packet, asserts reset while DAT0 is on the bus with
   // pend_v presented, then releases reset and returns after the first IDLE edge.
   task automatic reset_mid_packet(input logic [1:0] pend_v);
      pkt_t p;
      int   n;
      n    = 0;
      p    = rand_pkt();
      p.hd = 1'b1;
      cur[0] = p;
      req_v  = 2'b01;
      rdy    = 1'b1;
      drive();
      for (int i = 0; i < 20 && n < 3; i++) begin
         tick();
         if (sb.o_req_ack[0]) req_v[0] = 1'b0;
         if (sb.o_tx_valid) n++;
         drive();
      end
      check("rmp_reach_dat0", n, 3);
      check("rmp_dat0_word", sb.o_tx_data, p.d[63:32]);
      cur[0] = rand_pkt();
      cur[1] = rand_pkt();
      req_v  = pend_v;
      rst    = 1'b1;
      drive();
      tick();
      check("rmp_valid", sb.o_tx_valid, 1'b0);
      check("rmp_busy", busy, 1'b0);
      check("rmp_ack", sb.o_req_ack, 2'b00);
      check("rmp_data", sb.o_tx_data, 32'h0);
      check("rmp_last", sb.o_tx_last, 1'b0);
      rst = 1'b0;
      tick();
      model_reset();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      pkt_t p;
      int   total_words;
      cur[0]    = rand_pkt();
      cur[1]    = rand_pkt();
      req_v     = 2'b00;
      rdy       = 1'b0;
      ready_pct = 100;
      req_pct   = 100;
      bp_mode   = 1'b0;
      model_reset();
      drive();

      reset_dut();
      check("rst_valid", sb.o_tx_valid, 1'b0);
      check("rst_data", sb.o_tx_data, 32'h0);
      check("rst_last", sb.o_tx_last, 1'b0);
      check("rst_ack", sb.o_req_ack, 2'b00);
      check("rst_busy", busy, 1'b0);

      // Header-only packet from requester 0.
      clear_logs();
      p = '{p0: 32'h0000_0001, p1: 30'h0, hd: 1'b0, d: 64'hdead_beef_cafe_f00d};
      pend0.push_back(p);
      run_until_idle(100);
      check("ho_words", got_q.size(), 2);
      if (got_q.size() == 2) begin
         check("ho_w0", got_q[0], {1'b0, 32'h0000_0001});
         check("ho_w1", got_q[1], {1'b1, 32'h4000_0000});
      end
      if (ack_cyc.size() == 1 && last_cyc.size() == 1 && req_cyc.size() == 1) begin
         check("ho_ack_who", ack_who[0], 0);
         check("ho_ack_lat", ack_cyc[0] - req_cyc[0], 1);
         check("ho_last_lat", last_cyc[0] - ack_cyc[0], 2);
      end else begin
         check("ho_events", ack_cyc.size() + last_cyc.size(), 2);
      end

      // Data packet from requester 1.
      clear_logs();
      p = '{p0: 32'h0, p1: 30'h1, hd: 1'b1, d: 64'h3};
      pend1.push_back(p);
      run_until_idle(100);
      check("dp_words", got_q.size(), 4);
      if (got_q.size() == 4) begin
         check("dp_w0", got_q[0], {1'b0, 32'h0000_0000});
         check("dp_w1", got_q[1], {1'b0, 32'h4000_0001});
         check("dp_w2", got_q[2], {1'b0, 32'h0000_0000});
         check("dp_w3", got_q[3], {1'b1, 32'h0000_0003});
      end
      if (ack_cyc.size() == 1 && last_cyc.size() == 1) begin
         check("dp_ack_who", ack_who[0], 1);
         check("dp_last_lat", last_cyc[0] - ack_cyc[0], 4);
      end else begin
         check("dp_events", ack_cyc.size() + last_cyc.size(), 2);
      end

      // Both requesters continuously valid: alternating grants, fixed gap.
      reset_dut();
      clear_logs();
      repeat (2) begin
         pend0.push_back(rand_pkt());
         pend1.push_back(rand_pkt());
      end
      run_until_idle(200);
      check("rr_grants", ack_who.size(), 4);
      for (int i = 0; i < ack_who.size(); i++) check("rr_order", ack_who[i], i % 2);
      for (int i = 0; i + 1 < ack_cyc.size() && i < last_cyc.size(); i++)
         check("rr_gap", ack_cyc[i + 1] - last_cyc[i], GAP + 1);

      // Back-pressure: three stall cycles each in HDR1 and DAT0.
      clear_logs();
      bp_mode = 1'b1;
      p       = rand_pkt();
      p.hd    = 1'b1;
      pend0.push_back(p);
      run_until_idle(100);
      bp_mode = 1'b0;
      check("bp_words", got_q.size(), 4);
      if (ack_cyc.size() == 1 && last_cyc.size() == 1)
         check("bp_last_lat", last_cyc[0] - ack_cyc[0], 4 + 6);
      else
         check("bp_events", ack_cyc.size() + last_cyc.size(), 2);

      // Randomized traffic with random back-pressure and request timing.
      clear_logs();
      ready_pct   = 70;
      req_pct     = 60;
      total_words = 0;
      for (int i = 0; i < 1000; i++) begin
         p = rand_pkt();
         total_words += p.hd ? 4 : 2;
         if ($urandom_range(1) == 1) pend1.push_back(p);
         else pend0.push_back(p);
      end
      run_until_idle(40000);
      check("rand_grants", ack_who.size(), 1000);
      check("rand_words", got_q.size(), total_words);
      ready_pct = 100;
      req_pct   = 100;

      // Reset during DAT0 with requester 1 pending.
      clear_logs();
      reset_mid_packet(2'b10);
      check("rmp_ack_req1", sb.o_req_ack, 2'b10);
      model_push(cur[1]);
      model_rr = 1'b0;
      req_v[1] = 1'b0;
      drive();
      run_until_idle(100);
      check("rmp_req1_words", got_q.size(), cur[1].hd ? 4 : 2);

      // Reset during DAT0 after a req0 grant: a tie must go back to requester 0.
      clear_logs();
      reset_mid_packet(2'b11);
      check("rmp_rr_reset", sb.o_req_ack, 2'b01);
      model_push(cur[0]);
      model_rr = 1'b1;
      req_v[0] = 1'b0;
      drive();
      run_until_idle(100);
      check("rmp_tie_grants", ack_who.size(), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
